lv1_req_router: RTL and testbench



---
 rtl/lv1_req_router.sv | 180 ++++++++++++++++++
 tb/tb_lv1_req_router.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lv1_req_router.sv
// Per-core level-1 request router: decodes each CPU access to one of NUM_CH sub-caches,
// tracks it to completion or timeout, and round-robin arbitrates the shared lv1-lv2 bus.
module lv1_req_router #(
  parameter int unsigned                NUM_CH        = 2,
  parameter int unsigned                ADDR_WID      = 32,
  parameter logic [NUM_CH*ADDR_WID-1:0] REGION_BOUNDS = {32'hFFFF_FFFF, 32'h3FFF_FFFF},
  parameter logic [NUM_CH-1:0]          RO_MASK       = 2'b01,
  parameter int unsigned                TIMEOUT       = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_WID-1:0] addr_bus_cpu_lv1,
  output logic                cpu_done,
  output logic                cpu_err,
  output logic                busy,
  output logic [NUM_CH-1:0]   ch_rd,
  output logic [NUM_CH-1:0]   ch_wr,
  input  logic [NUM_CH-1:0]   ch_done,
  input  logic [NUM_CH-1:0]   ch_bus_req,
  output logic [NUM_CH-1:0]   ch_bus_gnt,
  output logic                bus_lv1_lv2_req_proc,
  input  logic                bus_lv1_lv2_gnt_proc
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic              is_wr_q, is_wr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_err_q, cpu_err_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] ch_rd_q, ch_rd_d;
  logic [NUM_CH-1:0] ch_wr_q, ch_wr_d;
  logic              owner_vld_q, owner_vld_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;

  logic              hit_vld;
  logic [CH_W-1:0]   hit_idx;
  logic [CH_W-1:0]   cand;

  // Bounds ascend, so the lowest channel whose upper bound covers the address owns it.
  always_comb begin
    hit_vld = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (addr_bus_cpu_lv1 <= REGION_BOUNDS[i*ADDR_WID +: ADDR_WID]) begin
        hit_vld = 1'b1;
        hit_idx = CH_W'(i);
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_rd | cpu_wr) begin
          if ((cpu_rd ^ cpu_wr) && hit_vld && !(cpu_wr && RO_MASK[hit_idx])) begin
            state_d = S_WAIT;
            sel_d   = hit_idx;
            is_wr_d = cpu_wr;
            err_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (ch_done[sel_q]) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  if (!cpu_rd && !cpu_wr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the next state, so they change one edge after decode.
    cpu_done_d = (state_d == S_RESP);
    cpu_err_d  = (state_d == S_RESP) && err_d;
    busy_d     = (state_d != S_IDLE);
    ch_rd_d    = '0;
    ch_wr_d    = '0;
    if (state_d == S_WAIT) begin
      ch_rd_d[sel_d] = !is_wr_d;
      ch_wr_d[sel_d] = is_wr_d;
    end
  end

  // Owner is sticky until its own request drops; a new owner is only chosen with the bus granted.
  always_comb begin
    owner_vld_d = owner_vld_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cand        = '0;
    if (owner_vld_q) begin
      if (!ch_bus_req[owner_q]) begin
        owner_vld_d = 1'b0;
        ptr_d       = owner_q;
      end
    end else if (bus_lv1_lv2_gnt_proc) begin
      for (int k = NUM_CH; k >= 1; k--) begin
        cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
        if (ch_bus_req[cand]) begin
          owner_vld_d = 1'b1;
          owner_d     = cand;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      is_wr_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      ch_rd_q     <= '0;
      ch_wr_q     <= '0;
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= CH_W'(NUM_CH - 1);
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      is_wr_q     <= is_wr_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
      busy_q      <= busy_d;
      ch_rd_q     <= ch_rd_d;
      ch_wr_q     <= ch_wr_d;
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
    end
  end

  always_comb begin
    ch_bus_gnt = '0;
    if (owner_vld_q && bus_lv1_lv2_gnt_proc) ch_bus_gnt[owner_q] = 1'b1;
  end

  assign bus_lv1_lv2_req_proc = |ch_bus_req;
  assign cpu_done             = cpu_done_q;
  assign cpu_err              = cpu_err_q;
  assign busy                 = busy_q;
  assign ch_rd                = ch_rd_q;
  assign ch_wr                = ch_wr_q;

endmodule

// File: tb/tb_lv1_req_router.sv
// Self-checking bench for lv1_req_router: CPU transactions and bus arbitration against
// a behavioural model of region decode, completion timing and round-robin ownership.
module tb_lv1_req_router;

  localparam int          NCH   = 2;
  localparam int          TMO   = 1023;
  localparam logic [31:0] LOW_B = 32'h3FFF_FFFF;
  // Top region ends below the address space so the no-hit path is reachable.
  localparam logic [31:0] TOP_B = 32'hEFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] addr = '0;
  logic        cpu_done, cpu_err, busy;
  logic [1:0]  ch_rd, ch_wr, ch_bus_gnt;
  logic [1:0]  ch_done = '0, ch_bus_req = '0;
  logic        req_proc;
  logic        gnt_proc = 1'b0;
  logic [1:0]  ro_mask = 2'b01;

  int n_cmp = 0;
  int n_bad = 0;

  lv1_req_router #(
    .NUM_CH(NCH), .ADDR_WID(32), .REGION_BOUNDS({TOP_B, LOW_B}),
    .RO_MASK(2'b01), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .addr_bus_cpu_lv1(addr), .cpu_done(cpu_done), .cpu_err(cpu_err), .busy(busy),
    .ch_rd(ch_rd), .ch_wr(ch_wr), .ch_done(ch_done), .ch_bus_req(ch_bus_req),
    .ch_bus_gnt(ch_bus_gnt), .bus_lv1_lv2_req_proc(req_proc),
    .bus_lv1_lv2_gnt_proc(gnt_proc)
  );

  always #5 clk = ~clk;

  function automatic int region_of(input logic [31:0] a);
    if (a <= LOW_B) return 0;
    if (a <= TOP_B) return 1;
    return -1;
  endfunction

  // Channel the request should go to, or -1 when it must be refused.
  function automatic int expect_sel(input logic rd, input logic wr, input logic [31:0] a);
    int r;
    r = region_of(a);
    if (rd == wr) return -1;
    if (r < 0) return -1;
    if (wr && ro_mask[r]) return -1;
    return r;
  endfunction

  // Drives one CPU transaction from IDLE and compares it to the model. lat = WAIT cycles
  // before ch_done (0 = never), hold = cycles the request stays up after cpu_done.
  task automatic run_cpu_txn(input string name, input logic rd, input logic wr,
                             input logic [31:0] a, input int lat, input int hold,
                             input bit scramble);
    int         esel, exp_done_at, done_at, pulses;
    logic [1:0] onehot, exp_rd, exp_wr, strobe_after;
    logic [4:0] first_obs;
    logic       exp_err, err, busy_end, strobe_bad;
    esel        = expect_sel(rd, wr, a);
    onehot      = (esel >= 0) ? 2'(1 << esel) : 2'b00;
    exp_rd      = (esel >= 0 && !wr) ? onehot : 2'b00;
    exp_wr      = (esel >= 0 && wr) ? onehot : 2'b00;
    exp_done_at = (esel < 0) ? 0 : ((lat > 0) ? lat : TMO);
    exp_err     = (esel < 0) || (lat == 0);
    done_at = -1; pulses = 0; err = 1'b0; strobe_after = '0; strobe_bad = 1'b0;
    first_obs = '0;
    cpu_rd = rd; cpu_wr = wr; addr = a;
    for (int c = 0; c < TMO + 20; c++) begin
      @(posedge clk);
      #1;
      if (scramble) addr = $urandom;
      ch_done = (esel >= 0 && c + 1 == lat) ? onehot : (2'($urandom) & ~onehot);
      @(negedge clk);
      if (c == 0) first_obs = {busy, ch_rd, ch_wr};
      if (cpu_done) begin
        pulses++;
        if (done_at < 0) begin done_at = c; err = cpu_err; end
      end
      if (done_at >= 0) strobe_after |= ch_rd | ch_wr;
      else if ({ch_rd, ch_wr} !== {exp_rd, exp_wr}) strobe_bad = 1'b1;
      if (done_at >= 0 && c >= done_at + hold) break;
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0; ch_done = '0;
    @(posedge clk);
    @(negedge clk);
    if (cpu_done) pulses++;
    busy_end = busy;

    n_cmp++;
    if (first_obs !== {1'b1, exp_rd, exp_wr}) begin
      n_bad++; $display("FAIL %s first_cycle {busy,rd,wr} got %b want %b", name, first_obs, {1'b1, exp_rd, exp_wr});
    end
    n_cmp++;
    if (strobe_bad !== 1'b0) begin
      n_bad++; $display("FAIL %s strobe_during_wait changed got %b want 0", name, strobe_bad);
    end
    n_cmp++;
    if (done_at !== exp_done_at) begin
      n_bad++; $display("FAIL %s done_latency got %0d want %0d", name, done_at, exp_done_at);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_bad++; $display("FAIL %s cpu_err got %b want %b", name, err, exp_err);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++; $display("FAIL %s done_pulses got %0d want 1", name, pulses);
    end
    n_cmp++;
    if (strobe_after !== 2'b00) begin
      n_bad++; $display("FAIL %s strobe_after_done got %b want 00", name, strobe_after);
    end
    n_cmp++;
    if (busy_end !== 1'b0) begin
      n_bad++; $display("FAIL %s busy_after_release got %b want 0", name, busy_end);
    end
  endtask

  task automatic test_reset;
    ch_bus_req = 2'b11; gnt_proc = 1'b1;
    #3;
    n_cmp++;
    if ({cpu_done, cpu_err, busy, ch_rd, ch_wr, ch_bus_gnt} !== 9'b0) begin
      n_bad++; $display("FAIL reset_outputs got %b want 0", {cpu_done, cpu_err, busy, ch_rd, ch_wr, ch_bus_gnt});
    end
    n_cmp++;
    if (req_proc !== 1'b1) begin
      n_bad++; $display("FAIL reset_req_proc got %b want 1", req_proc);
    end
    ch_bus_req = '0; gnt_proc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bus_alternate;
    logic [1:0] exp_seq [7];
    logic [1:0] got;
    exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
    ch_bus_req = 2'b11; gnt_proc = 1'b1;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      case (s)
        3: begin gnt_proc = 1'b0; #1; end
        default: ;
      endcase
      got = ch_bus_gnt;
      n_cmp++;
      if (got !== exp_seq[s]) begin
        n_bad++; $display("FAIL bus_alternate step %0d gnt got %b want %b", s, got, exp_seq[s]);
      end
      case (s)
        0: ch_bus_req = 2'b10;
        1: ch_bus_req = 2'b11;
        3: gnt_proc = 1'b1;
        4: ch_bus_req = 2'b01;
        5: ch_bus_req = 2'b11;
        default: ;
      endcase
    end
    ch_bus_req = '0; gnt_proc = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpu_directed;
    run_cpu_txn("read_ch0", 1'b1, 1'b0, 32'h0000_1000, 3, 1, 1'b0);
    run_cpu_txn("ro_write_ch0", 1'b0, 1'b1, 32'h0000_1000, 2, 1, 1'b0);
    run_cpu_txn("write_ch1", 1'b0, 1'b1, 32'h8000_0000, 4, 1, 1'b0);
    run_cpu_txn("read_no_hit", 1'b1, 1'b0, 32'hF000_0000, 2, 1, 1'b0);
    run_cpu_txn("rd_and_wr", 1'b1, 1'b1, 32'h8000_0000, 2, 2, 1'b0);
    run_cpu_txn("bound_low_top", 1'b0, 1'b1, LOW_B, 1, 1, 1'b0);
    run_cpu_txn("bound_low_plus1", 1'b0, 1'b1, LOW_B + 32'd1, 1, 1, 1'b0);
    run_cpu_txn("bound_top_plus1", 1'b1, 1'b0, TOP_B + 32'd1, 1, 1, 1'b0);
  endtask

  task automatic test_hold_and_addr_change;
    run_cpu_txn("held_request", 1'b1, 1'b0, 32'h8000_0040, 2, 6, 1'b0);
    run_cpu_txn("addr_change_wait", 1'b1, 1'b0, 32'h0000_2000, 5, 2, 1'b1);
  endtask

  task automatic test_back_to_back;
    run_cpu_txn("b2b_0", 1'b1, 1'b0, 32'h0000_0010, 1, 1, 1'b0);
    run_cpu_txn("b2b_1", 1'b0, 1'b1, 32'h9000_0000, 1, 1, 1'b0);
    run_cpu_txn("b2b_2", 1'b0, 1'b1, 32'h0000_0020, 1, 1, 1'b0);
    run_cpu_txn("b2b_3", 1'b1, 1'b0, 32'h4000_0000, 1, 1, 1'b0);
  endtask

  task automatic test_timeout;
    run_cpu_txn("timeout", 1'b1, 1'b0, 32'h0000_3000, 0, 1, 1'b0);
  endtask

  task automatic test_random_cpu;
    logic [31:0] a;
    logic        rd, wr;
    int          op;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: a = LOW_B;
        1: a = LOW_B + 32'd1;
        2: a = TOP_B;
        3: a = TOP_B + 32'd1;
        4: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      op = $urandom_range(0, 5);
      rd = (op <= 2) || (op == 5);
      wr = (op >= 3);
      run_cpu_txn("random_txn", rd, wr, a, $urandom_range(1, 6), $urandom_range(1, 3),
                  1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_random_bus;
    int         owner, last;
    logic [1:0] exp_gnt;
    owner = -1; last = NCH - 1;
    ch_bus_req = '0; gnt_proc = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      exp_gnt = (owner >= 0 && gnt_proc) ? 2'(1 << owner) : 2'b00;
      n_cmp++;
      if (ch_bus_gnt !== exp_gnt) begin
        n_bad++; $display("FAIL bus_random cyc %0d gnt got %b want %b", cyc, ch_bus_gnt, exp_gnt);
      end
      n_cmp++;
      if (req_proc !== (|ch_bus_req)) begin
        n_bad++; $display("FAIL bus_random cyc %0d req_proc got %b want %b", cyc, req_proc, |ch_bus_req);
      end
      for (int i = 0; i < NCH; i++) begin
        if (!ch_bus_req[i]) ch_bus_req[i] = ($urandom_range(0, 2) == 0);
        else if (owner == i && $urandom_range(0, 1) == 1) ch_bus_req[i] = 1'b0;
      end
      gnt_proc = ($urandom_range(0, 3) != 0);
      // Ownership after the coming edge, from the inputs now applied.
      if (owner >= 0) begin
        if (!ch_bus_req[owner]) begin last = owner; owner = -1; end
      end else if (gnt_proc) begin
        for (int k = 1; k <= NCH; k++) begin
          if (ch_bus_req[(last + k) % NCH]) begin owner = (last + k) % NCH; break; end
        end
      end
    end
    ch_bus_req = '0; gnt_proc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    logic stray;
    stray = 1'b0;
    @(negedge clk);
    cpu_rd = 1'b1; addr = 32'h0000_1000;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ch_rd !== 2'b01) begin
      n_bad++; $display("FAIL mid_wait_precondition ch_rd got %b want 01", ch_rd);
    end
    #2 rst_n = 1'b0; cpu_rd = 1'b0;
    #1;
    n_cmp++;
    if ({ch_rd, ch_wr, busy, cpu_done} !== 6'b0) begin
      n_bad++; $display("FAIL reset_async_drop got %b want 0", {ch_rd, ch_wr, busy, cpu_done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (cpu_done || busy || (|ch_rd) || (|ch_wr)) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_stray_activity got %b want 0", stray);
    end
    run_cpu_txn("after_reset", 1'b1, 1'b0, 32'h0000_1000, 2, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_bus_alternate();
    test_cpu_directed();
    test_hold_and_addr_change();
    test_back_to_back();
    test_timeout();
    test_random_cpu();
    test_random_bus();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
